chunked_adder: RTL

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, holding the inter-chunk carry in a register. It generalises the team's 4-bit ripple adder to arbitrary width, adds a subtract mode with signed-overflow detection, and wraps it in valid/ready handshakes so it can sit between pipeline stages of the datapath.

---
 rtl/chunked_adder.sv | 116 +++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, carrying between chunks in a register, behind valid/ready handshakes.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] sum_next;
  logic             last_chunk;
  logic             msb_carry_in;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Slice the current chunk out with shifts so the chunk position can be a plain counter.
  always_comb begin
    shamt        = 32'(idx) * 32'(CHUNK);
    chunk_a      = CHUNK'(opa >> shamt);
    chunk_b      = CHUNK'(opb >> shamt);
    chunk_res    = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
    sum_next     = (sum & ~(CHUNK_MASK << shamt))
                 | (WIDTH'(chunk_res[CHUNK-1:0]) << shamt);
    last_chunk   = (idx == LAST_IDX);
    // Carry into the MSB recovered from the top bit of the last chunk's sum.
    msb_carry_in = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_res[CHUNK-1];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Subtraction is a + ~b + ~cin, so the inversion happens once at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum   <= sum_next;
          carry <= chunk_res[CHUNK];
          idx   <= last_chunk ? '0 : idx + 1'b1;
          if (last_chunk) begin
            cout <= chunk_res[CHUNK];
            ovf  <= msb_carry_in ^ chunk_res[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
